if_fetch_unit: RTL

- Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register.
- Owns the PC and issues requests to instruction memory over a req/ack handshake.
- Applies hazard-unit stalls and branch/jump redirects, and presents PC+4, the fetched instruction and a valid bit to IF/ID.
- Generates the one-cycle flush pulse consumed by IF/ID.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/if_fetch_unit_next_pc_sel.sv | 29 ++
 rtl/if_fetch_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
//   NOP_INSN     : instruction presented to IF/ID when nothing valid is delivered
//   PC_INC       : sequential PC increment in bytes
//   RESET_PC_DEF : default PC loaded on reset
//   fetch_state_e: fetch sequencer states
package pipeline_pkg;

    localparam logic [31:0] NOP_INSN     = 32'h0000_0000;
    localparam int unsigned PC_INC       = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding at pc (or about to be raised)
        HOLD  = 2'd1,   // stalled with a fetched word parked in the skid register
        DRAIN = 2'd2    // redirected while a request was in flight; wait out its ack
    } fetch_state_e;

endpackage : pipeline_pkg

// File: rtl/if_fetch_unit_next_pc_sel.sv
// Redirect priority and target selection for the fetch stage.
// Ports:
//   br_taken_i/br_target_i     : resolved-taken branch from EX (older, wins)
//   jump_i/jump_target_i       : decoded jump from ID
//   redirect_o                 : any redirect requested this cycle
//   target_o                   : selected target, word-aligned
module next_pc_sel
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] target_o
);

    logic [ADDR_W-1:0] sel;

    always_comb begin
        redirect_o = br_taken_i | jump_i;
        sel        = br_taken_i ? br_target_i : jump_target_i;
        // Low two bits cleared so the PC always points at a whole word.
        target_o   = sel & ~ADDR_W'(3);
    end

endmodule : next_pc_sel

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register.
// Owns the PC, drives instruction memory over a req/ack handshake, applies
// hazard stalls (PCWrite) and branch/jump redirects, and presents PC+4,
// the instruction and a valid bit to IF/ID along with a one-cycle flush.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   PCWrite                    : 0 = stall from hazard unit
//   br_taken, br_target        : branch redirect (priority)
//   jump, jump_target          : jump redirect
//   imem_req, imem_addr        : fetch request, held until imem_ack
//   imem_ack, imem_rdata       : memory response
//   PCaddout, ins_out          : PC+4 and instruction to IF/ID
//   ins_valid                  : delivered word is valid (ins_out = nop otherwise)
//   flush                      : one-cycle pulse per accepted redirect
module if_fetch_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PCWrite,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] PCaddout,
    output logic [31:0]       ins_out,
    output logic              ins_valid,
    output logic              flush
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pcadd_q, pcadd_d;
    logic [31:0]       ins_q, ins_d;
    logic              valid_q, valid_d;
    logic              flush_q, flush_d;
    logic [31:0]       skid_ins_q, skid_ins_d;
    logic [ADDR_W-1:0] skid_pc4_q, skid_pc4_d;

    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_plus4;
    logic              ack_v;

    next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
        .br_taken_i    (br_taken),
        .br_target_i   (br_target),
        .jump_i        (jump),
        .jump_target_i (jump_target),
        .redirect_o    (redirect),
        .target_o      (target)
    );

    // Wraps modulo 2^ADDR_W by construction.
    assign pc_plus4 = pc_q + ADDR_W'(PC_INC);
    // An ack only means something while our request is actually raised.
    assign ack_v    = req_q & imem_ack;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        pcadd_d    = pcadd_q;
        ins_d      = ins_q;
        valid_d    = valid_q;
        flush_d    = 1'b0;
        skid_ins_d = skid_ins_q;
        skid_pc4_d = skid_pc4_q;

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    pc_d    = target;
                    flush_d = 1'b1;
                    valid_d = 1'b0;
                    ins_d   = NOP_INSN;
                    // With nothing in flight the new target can be requested
                    // straight away; otherwise the old request must complete.
                    if (ack_v || !req_q) begin
                        req_d  = 1'b1;
                        addr_d = target;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (!req_q) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    valid_d = 1'b0;
                    ins_d   = NOP_INSN;
                end else if (ack_v) begin
                    if (PCWrite) begin
                        ins_d   = imem_rdata;
                        pcadd_d = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                        addr_d  = pc_plus4;
                    end else begin
                        // Word arrived during a stall: park it, outputs stay frozen.
                        skid_ins_d = imem_rdata;
                        skid_pc4_d = pc_plus4;
                        req_d      = 1'b0;
                        state_d    = HOLD;
                    end
                end else begin
                    valid_d = 1'b0;
                    ins_d   = NOP_INSN;
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    flush_d = 1'b1;
                    valid_d = 1'b0;
                    ins_d   = NOP_INSN;
                    req_d   = 1'b1;
                    addr_d  = target;
                    state_d = FETCH;
                end else if (PCWrite) begin
                    ins_d   = skid_ins_q;
                    pcadd_d = skid_pc4_q;
                    valid_d = 1'b1;
                    pc_d    = skid_pc4_q;
                    req_d   = 1'b1;
                    addr_d  = skid_pc4_q;
                    state_d = FETCH;
                end
            end

            DRAIN: begin
                if (redirect) begin
                    pc_d    = target;
                    flush_d = 1'b1;
                end
                // The stale word is dropped; the next request uses the newest pc.
                if (ack_v) begin
                    addr_d  = redirect ? target : pc_q;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            pcadd_q    <= '0;
            ins_q      <= NOP_INSN;
            valid_q    <= 1'b0;
            flush_q    <= 1'b0;
            skid_ins_q <= NOP_INSN;
            skid_pc4_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            pcadd_q    <= pcadd_d;
            ins_q      <= ins_d;
            valid_q    <= valid_d;
            flush_q    <= flush_d;
            skid_ins_q <= skid_ins_d;
            skid_pc4_q <= skid_pc4_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign PCaddout  = pcadd_q;
    assign ins_out   = ins_q;
    assign ins_valid = valid_q;
    assign flush     = flush_q;

endmodule : if_fetch_unit
